// File: rtl/sig_debounce_pkg.sv
// Shared types and default constants for the debounce stage and the edge detector downstream of it.
// The FSM encoding is fixed at 2 bits so that other blocks and benches can decode it.
package edge_det_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    PEND_HI = 2'd1,
    IDLE_HI = 2'd2,
    PEND_LO = 2'd3
  } db_state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DB_CYCLES   = 4;
  localparam int DEF_GLITCH_W    = 8;

  function automatic logic is_idle(db_state_e s);
    return (s == IDLE_LO) || (s == IDLE_HI);
  endfunction

endpackage

// File: rtl/sig_debounce_if.sv
// Signal bundle between an upstream driver (master) and the debounce stage (slave).
interface sig_debounce_if import edge_det_pkg::*; #(
  parameter int GLITCH_W = DEF_GLITCH_W
) ();

  logic                sig_in;
  logic                glitch_clr;
  logic                sig;
  logic                stable;
  logic [GLITCH_W-1:0] glitch_cnt;

  modport master (
    output sig_in,
    output glitch_clr,
    input  sig,
    input  stable,
    input  glitch_cnt
  );

  modport slave (
    input  sig_in,
    input  glitch_clr,
    output sig,
    output stable,
    output glitch_cnt
  );

endinterface

// File: rtl/sig_debounce_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level; every stage resets to 0.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/sig_debounce.sv
// Synchronises and debounces an asynchronous level, producing a glitch-free sig
// plus a saturating count of rejected pulses.
module sig_debounce import edge_det_pkg::*; #(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_CYCLES   = DEF_DB_CYCLES,
  parameter int GLITCH_W    = DEF_GLITCH_W
) (
  input  logic           clk,
  input  logic           rst,
  sig_debounce_if.slave  bus
);

  localparam int                  CNT_W      = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  logic                sync_q;
  db_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sig_q, sig_d;
  logic                stable_q, stable_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                abort;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.sig_in),
    .q   (sync_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE_LO;
      cnt_q    <= '0;
      sig_q    <= 1'b0;
      stable_q <= 1'b1;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sig_q    <= sig_d;
      stable_q <= stable_d;
      glitch_q <= glitch_d;
    end
  end

  // cnt holds the number of consecutive samples already seen at the new level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    abort   = 1'b0;
    case (state_q)
      IDLE_LO: begin
        if (sync_q) begin
          state_d = PEND_HI;
          cnt_d   = CNT_ONE;
        end
      end
      PEND_HI: begin
        if (!sync_q) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
          sig_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE_HI: begin
        if (!sync_q) begin
          state_d = PEND_LO;
          cnt_d   = CNT_ONE;
        end
      end
      PEND_LO: begin
        if (sync_q) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
          sig_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase

    // stable trails the state register by one edge.
    stable_d = is_idle(state_q);

    if (bus.glitch_clr) begin
      glitch_d = '0;
    end else if (abort && (glitch_q != GLITCH_MAX)) begin
      glitch_d = glitch_q + 1'b1;
    end else begin
      glitch_d = glitch_q;
    end
  end

  assign bus.sig        = sig_q;
  assign bus.stable     = stable_q;
  assign bus.glitch_cnt = glitch_q;

endmodule

// File: tb/tb_sig_debounce.sv
// Bench for sig_debounce: run-length reference model checked every cycle, directed
// boundary scenarios with literal expectations, then randomized level segments.
`timescale 1ns/1ps
module tb_sig_debounce;
  import edge_det_pkg::*;

  localparam int SYNC = DEF_SYNC_STAGES;
  localparam int DB   = DEF_DB_CYCLES;
  localparam int GW   = DEF_GLITCH_W;
  localparam int GMAX = (1 << GW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sig_debounce_if #(.GLITCH_W(GW)) bus ();

  sig_debounce #(
    .SYNC_STAGES (SYNC),
    .DB_CYCLES   (DB),
    .GLITCH_W    (GW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference: delay line of raw samples, accepted level, and length of the
  // current run of samples that disagree with the accepted level.
  bit hist[$];
  int m_lvl, m_run, m_gcnt;
  bit m_stable, m_s, m_abort;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
    m_lvl    = 0;
    m_run    = 0;
    m_gcnt   = 0;
    m_stable = 1'b1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
    end else begin
      m_s = hist.pop_front();
      hist.push_back(bus.sig_in);
      m_stable = (m_run == 0);
      m_abort  = 1'b0;
      if (int'(m_s) != m_lvl) begin
        m_run++;
        if (m_run == DB) begin
          m_lvl = int'(m_s);
          m_run = 0;
        end
      end else if (m_run > 0) begin
        m_abort = 1'b1;
        m_run   = 0;
      end
      if (bus.glitch_clr) m_gcnt = 0;
      else if (m_abort && m_gcnt < GMAX) m_gcnt++;
    end
  end

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_sig",    int'(bus.sig),        m_lvl);
    chk("model_stable", int'(bus.stable),     int'(m_stable));
    chk("model_glitch", int'(bus.glitch_cnt), m_gcnt);
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.sig_in     = 1'b0;
    bus.glitch_clr = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  int  rise_at, fall_at, lows, rises, hi_cycles, n;
  bit  prev;

  initial begin
    // 1: reset with input high, then full-latency rise
    bus.sig_in     = 1'b1;
    bus.glitch_clr = 1'b0;
    rst            = 1'b1;
    step(2);
    #1;
    chk("t1_rst_sig",    int'(bus.sig),        0);
    chk("t1_rst_stable", int'(bus.stable),     1);
    chk("t1_rst_glitch", int'(bus.glitch_cnt), 0);
    rst = 1'b0;
    step(5);
    chk("t1_sig_edge5", int'(bus.sig), 0);
    step(1);
    chk("t1_sig_edge6", int'(bus.sig), 1);
    $display("test 1: reset and release latency done");

    // 2: two-sample glitch
    do_reset();
    bus.sig_in = 1'b1;
    step(2);
    bus.sig_in = 1'b0;
    lows  = 0;
    rises = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (!bus.stable) lows++;
      if (bus.sig) rises++;
    end
    chk("t2_stable_low_cycles", lows, 2);
    chk("t2_sig_high_cycles",   rises, 0);
    chk("t2_glitch",            int'(bus.glitch_cnt), 1);
    $display("test 2: short glitch done");

    // 3: clean rise and fall
    do_reset();
    bus.sig_in = 1'b1;
    rise_at = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (bus.sig && rise_at == 0) rise_at = i;
    end
    bus.sig_in = 1'b0;
    fall_at = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (!bus.sig && fall_at == 0) fall_at = i;
    end
    chk("t3_rise_edge", rise_at, 6);
    chk("t3_fall_edge", fall_at, 6);
    $display("test 3: rise at edge %0d, fall at edge %0d", rise_at, fall_at);

    // 4: width boundary, DB-1 samples rejected, DB samples accepted
    bus.sig_in = 1'b1;
    step(DB - 1);
    bus.sig_in = 1'b0;
    rises = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (bus.sig) rises++;
    end
    chk("t4_short_sig_high", rises, 0);
    chk("t4_short_glitch",   int'(bus.glitch_cnt), 1);
    bus.sig_in = 1'b1;
    step(DB);
    bus.sig_in = 1'b0;
    hi_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (bus.sig) hi_cycles++;
    end
    chk("t4_accept_hi_cycles", hi_cycles, 4);
    chk("t4_accept_glitch",    int'(bus.glitch_cnt), 1);
    $display("test 4: width boundary done");

    // 5: saturation, then clear coincident with an abort
    do_reset();
    for (int i = 0; i < 258; i++) begin
      bus.sig_in = 1'b1;
      step(1);
      bus.sig_in = 1'b0;
      step(1);
    end
    step(4);
    chk("t5_saturated", int'(bus.glitch_cnt), GMAX);
    bus.sig_in = 1'b1;
    step(1);
    bus.sig_in = 1'b0;
    step(2);
    chk("t5_pre_clr", int'(bus.glitch_cnt), GMAX);
    bus.glitch_clr = 1'b1;
    step(1);
    bus.glitch_clr = 1'b0;
    chk("t5_clr_wins", int'(bus.glitch_cnt), 0);
    step(3);
    chk("t5_clr_hold", int'(bus.glitch_cnt), 0);
    $display("test 5: saturation and clear done");

    // 6: asynchronous reset while high and mid-pending, then toggling
    do_reset();
    bus.sig_in = 1'b1;
    step(7);
    chk("t6_high_before_rst", int'(bus.sig), 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_fall", int'(bus.sig), 0);
    step(1);
    rst = 1'b0;
    step(5);
    chk("t6_pend_stable", int'(bus.stable), 0);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_sig",    int'(bus.sig),        0);
    chk("t6_rst_stable", int'(bus.stable),     1);
    chk("t6_rst_glitch", int'(bus.glitch_cnt), 0);
    step(1);
    rst   = 1'b0;
    rises = 0;
    prev  = bus.sig;
    for (int i = 0; i < 20; i++) begin
      bus.sig_in = i[0];
      step(1);
      if (bus.sig && !prev) rises++;
      prev = bus.sig;
    end
    bus.sig_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (bus.sig && !prev) rises++;
      prev = bus.sig;
    end
    chk("t6_single_rise", rises, 1);
    chk("t6_final_sig",   int'(bus.sig), 1);
    $display("test 6: reset mid-operation and toggling done");

    // 7: randomized segments, checked every cycle against the model
    do_reset();
    for (int seg = 0; seg < 400; seg++) begin
      bus.sig_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) n = int'($urandom_range(DB, DB + 5));
      else n = int'($urandom_range(1, DB));
      for (int k = 0; k < n; k++) begin
        bus.glitch_clr = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 299) == 0) begin
          rst = 1'b1;
          step(1);
          rst = 1'b0;
        end
        step(1);
      end
    end
    bus.glitch_clr = 1'b0;
    step(DB + SYNC + 2);
    $display("test 7: random segments done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
